// File: rtl/al422_bam_writer_pkg.sv
// Shared definitions for the AL422 BAM packet writer and the panel-scan reader.
// Holds the FSM encoding, byte-layout constants and the OE on-time helper.
package al422_bam_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WRST = 4'd1,
    ST_HDR0 = 4'd2,
    ST_HDR1 = 4'd3,
    ST_HDR2 = 4'd4,
    ST_HDR3 = 4'd5,
    ST_HDR4 = 4'd6,
    ST_PIX  = 4'd7,
    ST_DONE = 4'd8
  } state_e;

  localparam int EOB_BIT = 6;
  localparam int EOF_BIT = 7;

  localparam int HDR_ROW_IDX    = 0;
  localparam int HDR_OE_LO_IDX  = 1;
  localparam int HDR_OE_HI_IDX  = 2;
  localparam int HDR_PAS_LO_IDX = 3;
  localparam int HDR_PAS_HI_IDX = 4;

  localparam int AL422_DEPTH = 393216;

  localparam int ROW_LSB   = 0;
  localparam int PHASE_LSB = 5;

  // OE active count for a plane: base << plane, clamped to 16 bits.
  function automatic logic [15:0] oe_active(input logic [15:0] base,
                                            input logic [2:0]  plane);
    logic [23:0] wide;
    wide = {8'h00, base} << plane;
    return (|wide[23:16]) ? 16'hFFFF : wide[15:0];
  endfunction

endpackage

// File: rtl/al422_bam_writer_if.sv
// AL422 write-port bundle between the packet writer (master) and the FIFO pins (slave).
// A byte is transferred on every in_clk edge where al422_nwe_out is low; there is no
// back-pressure, the FIFO accepts every strobed byte and al422_nwrst_out low rewinds it.
interface al422_bam_writer_if;
  logic [7:0] al422_data_out;
  logic       al422_nwe_out;
  logic       al422_nwrst_out;

  modport master (
    output al422_data_out,
    output al422_nwe_out,
    output al422_nwrst_out
  );

  modport slave (
    input al422_data_out,
    input al422_nwe_out,
    input al422_nwrst_out
  );
endinterface

// File: rtl/al422_bam_writer_plane_sel.sv
// Registered bit-plane extractor: picks bit <plane> of the six colour fields of one
// frame-buffer word and packs it with the block/frame end flags into a pixel byte.
module al422_bam_plane_sel
  import al422_bam_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              load,
  input  logic [2:0]        plane,
  input  logic              eob,
  input  logic              eof,
  input  logic [6*BITS-1:0] mem_data,
  output logic [7:0]        pix_byte
);

  logic [5:0] bitv;
  logic [7:0] pix_n;

  // Field k sits at mem_data[k*BITS +: BITS]: 0..2 = lower B,G,R, 3..5 = upper B,G,R.
  always_comb begin
    bitv = '0;
    for (int k = 0; k < 6; k++) begin
      bitv[k] = |((mem_data[k*BITS +: BITS] >> plane) & BITS'(1));
    end
  end

  always_comb begin
    pix_n          = '0;
    pix_n[0]       = bitv[2];
    pix_n[1]       = bitv[1];
    pix_n[2]       = bitv[0];
    pix_n[3]       = bitv[5];
    pix_n[4]       = bitv[4];
    pix_n[5]       = bitv[3];
    pix_n[EOB_BIT] = eob;
    pix_n[EOF_BIT] = eof;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      pix_byte <= '0;
    end else if (load) begin
      pix_byte <= pix_n;
    end
  end

endmodule

// File: rtl/al422_bam_writer.sv
// AL422 BAM frame writer: streams header + pixel blocks (row outer, plane inner) into the FIFO.
// Optional byte_count/overflow ports are built when AL422_WR_BYTECOUNT_EN is defined.
module al422_bam_writer
  import al422_bam_pkg::*;
#(
  parameter int          COLS    = 64,
  parameter int          ROWS    = 16,
  parameter int          BITS    = 8,
  parameter logic [15:0] OE_BASE = 16'd8,
  localparam int         ADDR_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              frame_start,
  input  logic [2:0]        out_phases,
  input  logic [15:0]       oe_passive,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [6*BITS-1:0] mem_data,
  al422_bam_writer_if.master al422,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        dbg_state
`ifdef AL422_WR_BYTECOUNT_EN
  ,
  output logic [18:0]       byte_count,
  output logic              overflow
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [3:0] S_IDLE = ST_IDLE;
  localparam logic [3:0] S_WRST = ST_WRST;
  localparam logic [3:0] S_HDR0 = ST_HDR0;
  localparam logic [3:0] S_HDR1 = ST_HDR1;
  localparam logic [3:0] S_HDR2 = ST_HDR2;
  localparam logic [3:0] S_HDR3 = ST_HDR3;
  localparam logic [3:0] S_HDR4 = ST_HDR4;
  localparam logic [3:0] S_PIX  = ST_PIX;
  localparam logic [3:0] S_DONE = ST_DONE;

  logic [3:0]        st, st_n;
  logic              wrst_cnt;
  logic [CW-1:0]     col;
  logic [4:0]        row, prev_row;
  logic [2:0]        plane, prev_plane;
  logic [2:0]        phases_q;
  logic [15:0]       passive_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base;
  logic              accept, blk_end, last_blk, prefetch_ok;
  logic [3:0]        hdr_idx;
  logic [15:0]       oe_val;
  logic [7:0]        hdr_byte, hdr_q;
  logic              pix_q, nwe_q, nwrst_q, busy_q, done_q;
  logic [7:0]        pix_byte;

  // done_q marks the cycle the last-frame pulse is visible; a start there is dropped.
  assign accept   = (st == S_IDLE) && frame_start && !done_q;
  assign blk_end  = (st == S_PIX) && (col == CW'(COLS - 1));
  assign last_blk = (row == 5'(ROWS - 1)) && (plane == 3'(BITS - 1));
  assign row_base = ADDR_W'(int'(row) * COLS);
  assign prefetch_ok = (st == S_HDR4) ? (COLS > 1) : (int'(col) + 2 < COLS);

  always_comb begin
    st_n = st;
    case (st)
      S_IDLE:  if (accept) st_n = S_WRST;
      S_WRST:  if (wrst_cnt) st_n = S_HDR0;
      S_HDR0:  st_n = S_HDR1;
      S_HDR1:  st_n = S_HDR2;
      S_HDR2:  st_n = S_HDR3;
      S_HDR3:  st_n = S_HDR4;
      S_HDR4:  st_n = S_PIX;
      S_PIX:   if (blk_end) st_n = last_blk ? S_DONE : S_HDR0;
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  // Header fields describe the block the reader is about to display (prev_row/prev_plane).
  always_comb begin
    hdr_idx  = st - S_HDR0;
    oe_val   = oe_active(OE_BASE, prev_plane);
    hdr_byte = 8'h00;
    if (st >= S_HDR0 && st <= S_HDR4) begin
      case (hdr_idx)
        4'(HDR_ROW_IDX): begin
          hdr_byte[PHASE_LSB +: 3] = phases_q;
          hdr_byte[ROW_LSB +: 5]   = prev_row;
        end
        4'(HDR_OE_LO_IDX):  hdr_byte = oe_val[7:0];
        4'(HDR_OE_HI_IDX):  hdr_byte = oe_val[15:8];
        4'(HDR_PAS_LO_IDX): hdr_byte = passive_q[7:0];
        4'(HDR_PAS_HI_IDX): hdr_byte = passive_q[15:8];
        default:            hdr_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      st         <= S_IDLE;
      wrst_cnt   <= 1'b0;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      prev_row   <= '0;
      prev_plane <= '0;
      phases_q   <= '0;
      passive_q  <= '0;
      addr_q     <= '0;
      hdr_q      <= '0;
      pix_q      <= 1'b0;
      nwe_q      <= 1'b1;
      nwrst_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      st       <= st_n;
      wrst_cnt <= (st == S_WRST) ? ~wrst_cnt : 1'b0;

      if (accept) begin
        phases_q   <= out_phases;
        passive_q  <= oe_passive;
        row        <= '0;
        plane      <= '0;
        col        <= '0;
        prev_row   <= 5'(ROWS - 1);
        prev_plane <= 3'(BITS - 1);
        busy_q     <= 1'b1;
      end

      if (st == S_PIX) begin
        if (blk_end) begin
          col        <= '0;
          prev_row   <= row;
          prev_plane <= plane;
          if (plane == 3'(BITS - 1)) begin
            plane <= '0;
            row   <= row + 5'd1;
          end else begin
            plane <= plane + 3'd1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end

      // Address runs one cycle ahead of the column being captured by the plane selector.
      if (st == S_HDR3) begin
        addr_q <= row_base;
      end else if ((st == S_HDR4 || st == S_PIX) && prefetch_ok) begin
        addr_q <= addr_q + 1'b1;
      end

      // Pin-side outputs trail the state by one cycle so pixel bytes line up with headers.
      nwe_q   <= !(st >= S_HDR0 && st <= S_PIX);
      nwrst_q <= (st != S_WRST);
      hdr_q   <= hdr_byte;
      pix_q   <= (st == S_PIX);
      done_q  <= (st == S_DONE);
      if (st == S_DONE) busy_q <= 1'b0;
    end
  end

  al422_bam_plane_sel #(
    .BITS (BITS)
  ) u_plane_sel (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .load     (st == S_PIX),
    .plane    (plane),
    .eob      (blk_end),
    .eof      (blk_end && last_blk),
    .mem_data (mem_data),
    .pix_byte (pix_byte)
  );

  assign al422.al422_data_out  = pix_q ? pix_byte : hdr_q;
  assign al422.al422_nwe_out   = nwe_q;
  assign al422.al422_nwrst_out = nwrst_q;
  assign mem_addr              = addr_q;
  assign busy                  = busy_q;
  assign frame_done            = done_q;
  assign dbg_state             = st;

`ifdef AL422_WR_BYTECOUNT_EN
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (st == S_WRST) begin
        byte_count <= '0;
      end else if (!nwe_q) begin
        byte_count <= byte_count + 19'd1;
      end
      if (!nwe_q && (byte_count == 19'(AL422_DEPTH))) overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_al422_bam_writer.sv
// Directed bench for al422_bam_writer (ROWS=2, BITS=2, COLS=4) with a byte scoreboard.
// A second instance with OE_BASE=16'h9000 exercises OE saturation on the same stimulus.
module tb_al422_bam_writer;
  import al422_bam_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int BITS = 2;
  localparam int AW   = 3;
  localparam int NPIX = ROWS * COLS;
  localparam int FRAME_BYTES = ROWS * BITS * (5 + COLS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic [2:0]        phases = 3'b000;
  logic [15:0]       passive = 16'h0000;
  logic [AW-1:0]     addr_a, addr_b;
  logic [6*BITS-1:0] md_a, md_b;
  logic              busy_a, busy_b, done_a, done_b;
  logic [3:0]        st_a, st_b;
`ifdef AL422_WR_BYTECOUNT_EN
  logic [18:0]       bc_a, bc_b;
  logic              ov_a, ov_b;
`endif

  logic [6*BITS-1:0] fb [NPIX];

  logic [7:0] exp_q[$];
  logic [7:0] exp_sat_q[$];
  logic [7:0] cap_a [64];
  logic [7:0] cap_b [64];
  logic [7:0] exp_b;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_wr_b = 0;
  int n_wrst = 0;
  int first_wr = -1;
  int last_wr = -1;
  int last_wrst = -1;

  al422_bam_writer_if if_a ();
  al422_bam_writer_if if_b ();

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    md_a <= fb[addr_a];
    md_b <= fb[addr_b];
  end

  al422_bam_writer #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS), .OE_BASE(16'd8)) dut (
    .in_clk      (clk),
    .in_rst      (rst),
    .frame_start (frame_start),
    .out_phases  (phases),
    .oe_passive  (passive),
    .mem_addr    (addr_a),
    .mem_data    (md_a),
    .al422       (if_a),
    .busy        (busy_a),
    .frame_done  (done_a),
    .dbg_state   (st_a)
`ifdef AL422_WR_BYTECOUNT_EN
    ,
    .byte_count  (bc_a),
    .overflow    (ov_a)
`endif
  );

  al422_bam_writer #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS), .OE_BASE(16'h9000)) dut_sat (
    .in_clk      (clk),
    .in_rst      (rst),
    .frame_start (frame_start),
    .out_phases  (phases),
    .oe_passive  (passive),
    .mem_addr    (addr_b),
    .mem_data    (md_b),
    .al422       (if_b),
    .busy        (busy_b),
    .frame_done  (done_b),
    .dbg_state   (st_b)
`ifdef AL422_WR_BYTECOUNT_EN
    ,
    .byte_count  (bc_b),
    .overflow    (ov_b)
`endif
  );

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst && !if_a.al422_nwrst_out) begin
      n_wrst++;
      last_wrst = cyc;
    end
    if (!rst && !if_a.al422_nwe_out) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (n_wr < 64) cap_a[n_wr] = if_a.al422_data_out;
      n_wr++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_write_a obs=%02h exp=none", if_a.al422_data_out);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        n_vec++;
        assert (if_a.al422_data_out === exp_b) else begin
          n_err++;
          $error("FAIL byte_a[%0d] obs=%02h exp=%02h", n_wr - 1, if_a.al422_data_out, exp_b);
        end
      end
    end
    if (!rst && !if_b.al422_nwe_out) begin
      if (n_wr_b < 64) cap_b[n_wr_b] = if_b.al422_data_out;
      n_wr_b++;
      n_vec++;
      assert (exp_sat_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_write_b obs=%02h exp=none", if_b.al422_data_out);
      end
      if (exp_sat_q.size() != 0) begin
        exp_b = exp_sat_q.pop_front();
        n_vec++;
        assert (if_b.al422_data_out === exp_b) else begin
          n_err++;
          $error("FAIL byte_b[%0d] obs=%02h exp=%02h", n_wr_b - 1, if_b.al422_data_out, exp_b);
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input bit to_sat, input logic [7:0] b);
    if (to_sat) exp_sat_q.push_back(b);
    else        exp_q.push_back(b);
  endtask

  // Reference packet stream for one frame, built straight from the frame layout.
  task automatic push_frame(input logic [15:0] base, input bit to_sat);
    int rp, pp;
    logic [31:0] oe;
    logic [7:0]  b;
    logic [6*BITS-1:0] d;
    rp = ROWS - 1;
    pp = BITS - 1;
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < BITS; p++) begin
        oe = {16'h0000, base} << pp;
        if (oe > 32'h0000FFFF) oe = 32'h0000FFFF;
        push_byte(to_sat, {phases, 5'(rp)});
        push_byte(to_sat, oe[7:0]);
        push_byte(to_sat, oe[15:8]);
        push_byte(to_sat, passive[7:0]);
        push_byte(to_sat, passive[15:8]);
        for (int c = 0; c < COLS; c++) begin
          d    = fb[r * COLS + c];
          b[0] = d[2 * BITS + p];
          b[1] = d[1 * BITS + p];
          b[2] = d[0 * BITS + p];
          b[3] = d[5 * BITS + p];
          b[4] = d[4 * BITS + p];
          b[5] = d[3 * BITS + p];
          b[6] = (c == COLS - 1);
          b[7] = (c == COLS - 1) && (r == ROWS - 1) && (p == BITS - 1);
          push_byte(to_sat, b);
        end
        rp = r;
        pp = p;
      end
    end
  endtask

  task automatic new_frame(input logic [2:0] ph, input logic [15:0] pas);
    @(negedge clk);
    phases    = ph;
    passive   = pas;
    n_wr      = 0;
    n_wr_b    = 0;
    n_wrst    = 0;
    first_wr  = -1;
    last_wr   = -1;
    last_wrst = -1;
    push_frame(16'd8, 1'b0);
    push_frame(16'h9000, 1'b1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Waits for frame_done, then pulses frame_start in that very cycle (must be ignored).
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_a !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(k < 300), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_a), 32'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, "_done_pulse_1cyc"}, 32'(done_a), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_stats(input string tag);
    chk({tag, "_nwrst_cycles"}, 32'(n_wrst), 32'd2);
    chk({tag, "_writes"}, 32'(n_wr), 32'(FRAME_BYTES));
    chk({tag, "_writes_sat"}, 32'(n_wr_b), 32'(FRAME_BYTES));
    chk({tag, "_no_bubble"}, 32'(last_wr - first_wr + 1), 32'(FRAME_BYTES));
    chk({tag, "_wrst_to_write"}, 32'(first_wr - last_wrst), 32'd1);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_sat_q_empty"}, 32'(exp_sat_q.size()), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int snap;
    for (int i = 0; i < NPIX; i++) fb[i] = 12'($urandom_range(0, 4095));

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_nwe", 32'(if_a.al422_nwe_out), 32'd1);
    chk("rst_nwrst", 32'(if_a.al422_nwrst_out), 32'd1);
    chk("rst_data", 32'(if_a.al422_data_out), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(frame_done_or(done_a)), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // frame A: reference header values, plus a start pulse while busy
    new_frame(3'b001, 16'h0102);
    repeat (10) @(negedge clk);
    chk("a_busy_mid", 32'(busy_a), 32'd1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done("a");
    frame_stats("a");
    chk("a_hdr0", 32'(cap_a[0]), 32'h21);
    chk("a_hdr1", 32'(cap_a[1]), 32'h10);
    chk("a_hdr2", 32'(cap_a[2]), 32'h00);
    chk("a_hdr3", 32'(cap_a[3]), 32'h02);
    chk("a_hdr4", 32'(cap_a[4]), 32'h01);
    chk("a_blk2_hdr1", 32'(cap_a[10]), 32'h08);
    chk("a_blk2_hdr2", 32'(cap_a[11]), 32'h00);
    for (int blk = 0; blk < ROWS * BITS; blk++) begin
      chk("a_eob", 32'(cap_a[blk * 9 + 8][6]), 32'd1);
      chk("a_eof", 32'(cap_a[blk * 9 + 8][7]), 32'(blk == ROWS * BITS - 1));
    end
    chk("sat_hdr1", 32'(cap_b[1]), 32'hFF);
    chk("sat_hdr2", 32'(cap_b[2]), 32'hFF);
    chk("sat_blk2_hdr1", 32'(cap_b[10]), 32'h00);
    chk("sat_blk2_hdr2", 32'(cap_b[11]), 32'h90);
`ifdef AL422_WR_BYTECOUNT_EN
    chk("a_byte_count", 32'(bc_a), 32'(FRAME_BYTES));
    chk("a_overflow", 32'(ov_a), 32'd0);
`endif

    // frame B: only lower R lit -> every pixel byte is 8'h01 plus flags
    for (int i = 0; i < NPIX; i++) fb[i] = 12'h030;
    new_frame(3'b110, 16'hA55A);
    wait_done("b");
    frame_stats("b");
    chk("b_hdr0", 32'(cap_a[0]), 32'hC1);
    chk("b_pix_p0c0", 32'(cap_a[5]), 32'h01);
    chk("b_pix_p0c3", 32'(cap_a[8]), 32'h41);
    chk("b_pix_p1c1", 32'(cap_a[15]), 32'h01);
    chk("b_pix_last", 32'(cap_a[35]), 32'hC1);

    // frame C: reset while pixels stream out
    for (int i = 0; i < NPIX; i++) fb[i] = 12'($urandom_range(0, 4095));
    new_frame(3'b010, 16'h1234);
    k = 0;
    while (st_a !== ST_PIX && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("c_reached_pix", 32'(k < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("c_rst_nwe", 32'(if_a.al422_nwe_out), 32'd1);
    chk("c_rst_busy", 32'(busy_a), 32'd0);
    chk("c_rst_nwrst", 32'(if_a.al422_nwrst_out), 32'd1);
    chk("c_rst_state", 32'(st_a), 32'(ST_IDLE));
    rst = 1'b0;
    exp_q.delete();
    exp_sat_q.delete();
    snap = n_wr;
    repeat (5) @(negedge clk);
    chk("c_no_write_after_rst", 32'(n_wr), 32'(snap));

    // frame D: restart after the abort must begin with a pointer reset
    for (int i = 0; i < NPIX; i++) fb[i] = 12'($urandom_range(0, 4095));
    new_frame(3'b011, 16'($urandom_range(0, 65535)));
    wait_done("d");
    frame_stats("d");
`ifdef AL422_WR_BYTECOUNT_EN
    chk("d_byte_count", 32'(bc_a), 32'(FRAME_BYTES));
    chk("d_overflow", 32'(ov_a), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic frame_done_or(input logic v);
    return v;
  endfunction

endmodule
